// File: rtl/div_result_bcd_pkg.sv
// Shared definitions for the divider result BCD stage: operand width,
// digit count, FSM state type and the leading-zero mask helper that is
// used only when DIV_BCD_BLANK_EN is defined.
package div_pkg;

    localparam int DIV_W     = 8;
    localparam int DIV_BCD_D = 3;
    localparam int DIV_CNT_W = $clog2(DIV_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } div_bcd_state_t;

    // Bit i set means digit i is shown: it is nonzero or some higher
    // digit is nonzero. The units digit is always shown so that a zero
    // value still displays a single "0".
    function automatic logic [DIV_BCD_D-1:0] blank_mask(
        input logic [4*DIV_BCD_D-1:0] bcd
    );
        logic [DIV_BCD_D-1:0] mask;
        logic                 seen;
        mask = '0;
        seen = 1'b0;
        for (int i = DIV_BCD_D - 1; i >= 0; i--) begin
            seen    = seen | (bcd[4*i +: 4] != 4'd0);
            mask[i] = seen;
        end
        mask[0] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/div_result_bcd_if.sv
// Handshake bundle between the divider, the BCD stage and the display
// consumer. The q_blank signal exists only when DIV_BCD_BLANK_EN is defined.
interface div_result_bcd_if;
    import div_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [DIV_W-1:0]       quotient;
    logic [DIV_W-1:0]       remainder;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*DIV_BCD_D-1:0] q_bcd;
    logic [4*DIV_BCD_D-1:0] r_bcd;
`ifdef DIV_BCD_BLANK_EN
    logic [DIV_BCD_D-1:0]   q_blank;
`endif

    // Producer/consumer side: drives the divider result and the accept.
    modport master (
        output in_valid,
        output quotient,
        output remainder,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  q_bcd,
`ifdef DIV_BCD_BLANK_EN
        input  q_blank,
`endif
        input  r_bcd
    );

    // BCD converter side.
    modport slave (
        input  in_valid,
        input  quotient,
        input  remainder,
        input  out_ready,
        output in_ready,
        output out_valid,
        output q_bcd,
`ifdef DIV_BCD_BLANK_EN
        output q_blank,
`endif
        output r_bcd
    );

endinterface

// File: rtl/div_result_bcd_digit_adj.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before
// the shift so that it carries correctly into the next digit. The result
// never exceeds 12, so it stays within 4 bits and no carry leaves the cell.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    // Add-3 when the digit would overflow decimal after doubling.
    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end
    end

endmodule

// File: rtl/div_result_bcd.sv
// Divider result to packed BCD converter. Latches a quotient/remainder
// pair, runs both through a shift-and-add-3 engine one bit per clock and
// holds the BCD result until the consumer accepts it.
// Optional feature macro: DIV_BCD_BLANK_EN adds the registered q_blank
// leading-zero mask for the quotient.
module div_result_bcd
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    div_result_bcd_if.slave bus
);

    localparam int W = DIV_W;
    localparam int D = DIV_BCD_D;
    localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(W - 1);

    div_bcd_state_t       state;
    div_bcd_state_t       state_next;
    logic [W-1:0]         q_bin;
    logic [W-1:0]         r_bin;
    logic [4*D-1:0]       q_bcd;
    logic [4*D-1:0]       r_bcd;
    logic [4*D-1:0]       q_adj;
    logic [4*D-1:0]       r_adj;
    logic [4*D-1:0]       q_bcd_shift;
    logic [4*D-1:0]       r_bcd_shift;
    logic [DIV_CNT_W-1:0] bit_cnt;
    logic                 in_rdy;
    logic                 out_vld;
    logic                 accept;
    logic                 shift_en;
    logic                 release_out;

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode; in_ready depends only on the state.
    always_comb begin
        state_next  = state;
        in_rdy      = 1'b0;
        out_vld     = 1'b0;
        accept      = 1'b0;
        shift_en    = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                shift_en = 1'b1;
                if (bit_cnt == LAST_CNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_vld = 1'b1;
                if (bus.out_ready) begin
                    release_out = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    genvar g;
    generate
        for (g = 0; g < D; g++) begin : g_digit
            bcd_digit_adj u_q_adj (
                .digit    (q_bcd[4*g +: 4]),
                .adjusted (q_adj[4*g +: 4])
            );
            bcd_digit_adj u_r_adj (
                .digit    (r_bcd[4*g +: 4]),
                .adjusted (r_adj[4*g +: 4])
            );
        end
    endgenerate

    assign q_bcd_shift = {q_adj[4*D-2:0], q_bin[W-1]};
    assign r_bcd_shift = {r_adj[4*D-2:0], r_bin[W-1]};

    // Conversion datapath: load on accept, shift while converting and
    // clear the BCD result once the consumer has taken it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_bin   <= '0;
            r_bin   <= '0;
            q_bcd   <= '0;
            r_bcd   <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            q_bin   <= bus.quotient;
            r_bin   <= bus.remainder;
            q_bcd   <= '0;
            r_bcd   <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            q_bcd   <= q_bcd_shift;
            r_bcd   <= r_bcd_shift;
            q_bin   <= {q_bin[W-2:0], 1'b0};
            r_bin   <= {r_bin[W-2:0], 1'b0};
            bit_cnt <= bit_cnt + DIV_CNT_W'(1);
        end else if (release_out) begin
            q_bcd   <= '0;
            r_bcd   <= '0;
        end
    end

`ifdef DIV_BCD_BLANK_EN
    logic [D-1:0] q_blank;

    // Capture the display mask from the final quotient on the DONE entry edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_blank <= '0;
        end else if (shift_en && (bit_cnt == LAST_CNT)) begin
            q_blank <= blank_mask(q_bcd_shift);
        end
    end

    assign bus.q_blank = q_blank;
`endif

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.q_bcd     = q_bcd;
    assign bus.r_bcd     = r_bcd;

endmodule
